// File: rtl/mult_ctrl.sv
// mult_ctrl: iterative 32-cycle shift-add multiply controller owning HI/LO
// Ports: Clock_i/Reset_i (async, active-high); start_i, is_signed_i,
// multiplicando_i, multiplicador_i sampled in IDLE; abort_i flushes any
// operation; busy_o high while multiplying; done_o pulses with hi_o/lo_o valid.
module mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             Clock_i,
  input  logic             Reset_i,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] multiplicando_i,
  input  logic [WIDTH-1:0] multiplicador_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             state_q;
  logic [2*WIDTH-1:0] p_q;
  logic [4:0]         count_q;
  logic [WIDTH-1:0]   mcand_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;
  logic [WIDTH:0]     sum_d;
  // Magnitude of the most negative value wraps to itself, which is correct
  // once it is read as unsigned.
  always_comb begin
    a_mag_d = (is_signed_i & multiplicando_i[WIDTH-1]) ? -multiplicando_i : multiplicando_i;
    b_mag_d = (is_signed_i & multiplicador_i[WIDTH-1]) ? -multiplicador_i : multiplicador_i;
    sum_d   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, p_q[0] ? mcand_q : '0};
  end
  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q <= IDLE;
      p_q     <= '0;
      count_q <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start_i) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            neg_q   <= is_signed_i & (multiplicando_i[WIDTH-1] ^ multiplicador_i[WIDTH-1]);
            mcand_q <= a_mag_d;
            p_q     <= {{WIDTH{1'b0}}, b_mag_d};
            count_q <= '0;
          end
          RUN: begin
            p_q     <= {sum_d, p_q[WIDTH-1:1]};
            count_q <= count_q + 5'd1;
            if (count_q == 5'd31) state_q <= FIX;
          end
          FIX: begin
            {hi_q, lo_q} <= neg_q ? -p_q : p_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: self-checking bench for mult_ctrl against a countdown/product model
module tb_mult_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  int          errors = 0;
  int          checks = 0;
  int          m_rem;
  logic        m_done;
  logic [63:0] m_res;
  logic [63:0] m_prod;

  mult_ctrl #(.WIDTH(32)) dut (
    .Clock_i(clk), .Reset_i(rst), .start_i(start), .is_signed_i(sgn),
    .multiplicando_i(a), .multiplicador_i(b), .abort_i(abort),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] ex, ey;
    ex = s ? {{32{x[31]}}, x} : {32'b0, x};
    ey = s ? {{32{y[31]}}, y} : {32'b0, y};
    return ex * ey;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a request is accepted when nothing is pending; the result lands
  // exactly 33 edges later unless abort or reset intervenes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (abort) m_rem <= 0;
      else if (m_rem == 0) begin
        if (start) begin
          m_rem  <= 33;
          m_prod <= prod(a, b, sgn);
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_res  <= m_prod;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {63'b0, busy}, {63'b0, m_rem != 0});
    chk("done", {63'b0, done}, {63'b0, m_done});
    chk("hilo", {hi, lo}, m_res);
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic mul(input logic [31:0] x, input logic [31:0] y, input logic s,
                     input logic [63:0] exp, input string nm);
    int n, bc;
    start = 1'b1; a = x; b = y; sgn = s;
    @(negedge clk);
    start = 1'b0;
    n = 0; bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'd33);
    chk({nm, "_busycyc"}, 64'(bc), 64'd33);
    chk({nm, "_res"}, {hi, lo}, exp);
  endtask

  task automatic no_done(input int cyc, input string nm);
    int d;
    d = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (done) d++;
    end
    chk(nm, 64'(d), 64'd0);
  endtask

  initial begin
    #2;
    chk("rst_outs", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mul(32'd7, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFF_FFFFFFEB, "s7xm3");
    mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, "umax");
    mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1, "sm1");
    mul(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, "smin2");
    mul(32'h80000000, 32'h1, 1'b1, 64'hFFFFFFFF_80000000, "sminx1");
    // Stray start mid-run must be ignored.
    start = 1'b1; a = 5; b = 6; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; a = 9; b = 9;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("ign_res", {hi, lo}, 64'd30);
    no_done(40, "ign_single_done");
    // Abort mid-run.
    start = 1'b1; a = 3; b = 3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_lo", {32'b0, lo}, 64'd30);
    no_done(40, "abort_no_done");
    chk("abort_lo_kept", {32'b0, lo}, 64'd30);
    // Abort beats start in IDLE.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_pri", {63'b0, busy}, 64'd0);
    // Asynchronous reset mid-run.
    start = 1'b1; a = 3; b = 3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_mid", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Back-to-back.
    mul(32'd3, 32'd4, 1'b0, 64'd12, "b2b_1");
    mul(32'd0, 32'hFFFFFFFF, 1'b0, 64'd0, "b2b_2");
    // Random traffic; the per-cycle compare checks everything.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] x, y;
      logic s;
      int mode;
      x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 3);
      if (mode == 0) x = 32'h80000000;
      if (mode == 3) begin
        start = 1'b1; a = x; b = y; sgn = s;
        @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(0, 34)) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
      end else begin
        mul(x, y, s, prod(x, y, s), "rand");
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Iterative multiply controller for the multicycle MIPS datapath. It accepts a MULT/MULTU request from the main control unit and sequences a 32-iteration shift-add multiply over a fixed number of cycles. It owns the architectural HI/LO registers and holds `busy` high so the control unit stalls MFHI/MFLO and further multiplies until the product is committed.

## Interface
- `WIDTH`, 32, operand width; only 32 is supported.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request; sampled only in IDLE.
- `is_signed`  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with `start`.
- `multiplicando`  in  32  operand A; sampled with `start`.
- `multiplicador`  in  32  operand B; sampled with `start`.
- `abort`  in  1  pipeline flush; cancels any operation in flight.
- `busy`  out  1  high while RUN or FIX.
- `done`  out  1  one-cycle pulse; HI/LO are newly valid.
- `hi`  out  32  product[63:32], registered.
- `lo`  out  32  product[31:0], registered.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - `start`=1 and `abort`=0 → RUN.
  - Latch `neg` = `is_signed` & (A[31] ^ B[31]).
  - Latch `mcand` = |A| (A itself if unsigned).
  - Load P[63:0] = {32'b0, |B|} (B itself if unsigned).
  - Clear `count` to 0.
- Magnitude of 0x80000000 is 0x80000000, treated as a 32-bit unsigned value. No overflow case exists.
- RUN, each cycle:
  - `sum`[32:0] = P[63:32] + (P[0] ? `mcand` : 0), using a 33-bit add.
  - P ← {`sum`, P[31:1]}.
  - `count` ← `count`+1.
- RUN exits to FIX on the edge where `count`==31. This is the 32nd iteration; the 5-bit counter never wraps.
- FIX, one cycle:
  - hi:lo ← `neg` ? (~P + 1) : P, using 64-bit negation.
  - `done`←1.
  - Next state IDLE.
- Latency is fixed. Zero operands still take 32 iterations; there is no early exit.
- `start` in RUN or FIX is ignored; there is no queueing. Operand changes after acceptance are ignored.
- `abort` in any state:
  - Next state IDLE.
  - `done` stays 0; hi/lo are unchanged.
  - `abort` takes priority over `start` in the same cycle.
- `Reset` asserted at any time:
  - State=IDLE.
  - P, `count`, `mcand`, `neg` = 0.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - Takes effect immediately (asynchronous).
- `hi`/`lo` change only in FIX or on Reset.

## Timing
- Edge E0: `start` sampled in IDLE. From E0, `busy`=1.
- Edges E1..E32: the 32 RUN iterations.
- Edge E33: FIX commits hi/lo.
- After E33: `busy`=0, and `done`=1 for exactly one cycle with hi/lo valid in that same cycle.
- Request to result latency is 33 clocks.
- `busy` is registered. It deasserts in the same cycle `done` asserts.
- Back-to-back: `start` asserted in the `done` cycle is accepted, because the FSM is already in IDLE. Throughput is 1 multiply per 33 cycles.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then signed 7 × 0xFFFFFFFD (−3) → `done` exactly 33 edges after the `start` edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; `busy` high for 33 cycles.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Same operands signed (−1 × −1) → hi=0, lo=1.
- Signed 0x80000000 × 0x80000000 → hi=0x40000000, lo=0. Signed 0x80000000 × 1 → hi=0xFFFFFFFF, lo=0x80000000.
- Start 5 × 6, then pulse `start` with 9 × 9 at iteration 10 → second request ignored; hi=0, lo=30; single `done`.
- Prior result lo=30, then new start with `abort` at iteration 10 → `busy`=0 next cycle, no `done`, lo stays 30. Repeat with `Reset` mid-RUN → `busy`, `done`, `hi`, `lo` all 0 immediately.
- Back-to-back: 3 × 4, then `start` 0 × 0xFFFFFFFF in the `done` cycle → lo=12 at first `done`; second `done` 33 edges later with hi=lo=0.
